// File: rtl/axis_corr_sched_if.sv
// Bundle of the AXI-Stream channels around the correlator scheduler.
// Signals:
//   s_axis_*       : requester side, NUM_REQ lanes (slice i belongs to requester i)
//   m_axis_corr_*  : feed into the shared correlator
//   s_axis_corr_*  : beats coming back from the correlator
//   m_axis_*       : tagged results (tdest names the requester)
// Modports: master = scheduler view, slave = environment view.
interface axis_corr_sched_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SLAVE_WIDTH  = 64,
    parameter int unsigned MASTER_WIDTH = 128
);
    localparam int unsigned DEST_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             s_axis_tvalid;
    logic [NUM_REQ-1:0]             s_axis_tready;
    logic [NUM_REQ*SLAVE_WIDTH-1:0] s_axis_tdata;

    logic                           m_axis_corr_tvalid;
    logic                           m_axis_corr_tready;
    logic [SLAVE_WIDTH-1:0]         m_axis_corr_tdata;

    logic                           s_axis_corr_tvalid;
    logic                           s_axis_corr_tready;
    logic [MASTER_WIDTH-1:0]        s_axis_corr_tdata;

    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic [MASTER_WIDTH-1:0]        m_axis_tdata;
    logic [DEST_W-1:0]              m_axis_tdest;

    modport master (
        input  s_axis_tvalid, s_axis_tdata,
        input  m_axis_corr_tready,
        input  s_axis_corr_tvalid, s_axis_corr_tdata,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_corr_tvalid, m_axis_corr_tdata,
        output s_axis_corr_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tdest
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata,
        output m_axis_corr_tready,
        output s_axis_corr_tvalid, s_axis_corr_tdata,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_corr_tvalid, m_axis_corr_tdata,
        input  s_axis_corr_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tdest
    );
endinterface

// File: rtl/axis_corr_sched.sv
// Round-robin scheduler sharing one streaming correlator among NUM_REQ
// requesters. A granted requester streams BURST_LEN beats into the
// correlator; every fed beat pushes the requester index into a tag FIFO and
// every returned beat pops it to label the result with m_axis_tdest.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : axis_corr_sched_if.master (requester, feed, return, result)
//   tag_count     : tag FIFO occupancy
//   err_underflow : sticky, set by a return beat arriving with no tag queued
// Optional feature: define CORR_SCHED_TIMEOUT_EN to release a grant after
// TIMEOUT consecutive busy cycles with the granted requester idle.
module axis_corr_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SLAVE_WIDTH  = 64,
    parameter int unsigned MASTER_WIDTH = 128,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned TAG_DEPTH    = 8,
    parameter int unsigned TIMEOUT      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_corr_sched_if.master          bus,
    output logic [$clog2(TAG_DEPTH):0] tag_count,
    output logic                       err_underflow
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned AW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Elaboration-time parameter sanity
    if ((NUM_REQ < 2) || ((NUM_REQ & (NUM_REQ - 1)) != 0)) begin : g_bad_num_req
        $error("NUM_REQ must be a power of 2 and at least 2");
    end
    if ((TAG_DEPTH < 2) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0)) begin : g_bad_tag_depth
        $error("TAG_DEPTH must be a power of 2 and at least 2");
    end
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("BURST_LEN must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [BW-1:0] beat_q, beat_d;

    logic [GW-1:0] tag_mem_q [TAG_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          err_q;

    logic          tag_full_c, tag_empty_c;
    logic          push_c, pop_c, ret_fire_c;
    logic          hit_c;
    logic [GW-1:0] pick_c;

`ifdef CORR_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    assign tag_full_c  = (count_q == CW'(TAG_DEPTH));
    assign tag_empty_c = (count_q == '0);
    assign ret_fire_c  = bus.s_axis_corr_tvalid & bus.m_axis_tready;
    // An underflowing return is forwarded but must not disturb the FIFO
    assign pop_c       = ret_fire_c & ~tag_empty_c;

    // Round-robin search starting just after the last grant
    always_comb begin
        hit_c  = 1'b0;
        pick_c = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            if (!hit_c && bus.s_axis_tvalid[GW'(last_grant_q + GW'(i))]) begin
                hit_c  = 1'b1;
                pick_c = GW'(last_grant_q + GW'(i));
            end
        end
    end

    // Next-state and feed handshake
    always_comb begin
        state_d                = state_q;
        grant_d                = grant_q;
        last_grant_d           = last_grant_q;
        beat_d                 = beat_q;
        push_c                 = 1'b0;
        bus.s_axis_tready      = '0;
        bus.m_axis_corr_tvalid = 1'b0;
`ifdef CORR_SCHED_TIMEOUT_EN
        idle_cnt_d             = '0;
`endif
        case (state_q)
            IDLE: begin
                if (hit_c) begin
                    grant_d = pick_c;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.m_axis_corr_tvalid     = bus.s_axis_tvalid[grant_q] & ~tag_full_c;
                bus.s_axis_tready[grant_q] = bus.m_axis_corr_tready & ~tag_full_c;
                push_c = bus.s_axis_tvalid[grant_q] & bus.m_axis_corr_tready & ~tag_full_c;
                if (push_c) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
`ifdef CORR_SCHED_TIMEOUT_EN
                // Counter restarts whenever the granted requester shows valid
                if (!bus.s_axis_tvalid[grant_q]) begin
                    if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_q       <= '0;
`ifdef CORR_SCHED_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
`ifdef CORR_SCHED_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    // Tag occupancy: push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag FIFO pointers, occupancy and sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (ret_fire_c && tag_empty_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            tag_mem_q[wr_ptr_q] <= grant_q;
        end
    end

    assign bus.m_axis_corr_tdata  = bus.s_axis_tdata[grant_q*SLAVE_WIDTH +: SLAVE_WIDTH];
    assign bus.s_axis_corr_tready = bus.m_axis_tready;
    assign bus.m_axis_tvalid      = bus.s_axis_corr_tvalid;
    assign bus.m_axis_tdata       = MASTER_WIDTH'(bus.s_axis_corr_tdata);
    assign bus.m_axis_tdest       = tag_empty_c ? '0 : tag_mem_q[rd_ptr_q];

    assign tag_count     = count_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_axis_corr_sched.sv
`timescale 1ns/1ps
module tb_axis_corr_sched;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned SW        = 64;
    localparam int unsigned MW        = 128;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned TAG_DEPTH = 8;
    localparam int unsigned TIMEOUT   = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] tag_count;
    logic       err_underflow;
    int         n_checks = 0;
    int         n_pass   = 0;

    axis_corr_sched_if #(.NUM_REQ(NUM_REQ), .SLAVE_WIDTH(SW), .MASTER_WIDTH(MW)) bus ();

    axis_corr_sched #(
        .NUM_REQ(NUM_REQ), .SLAVE_WIDTH(SW), .MASTER_WIDTH(MW),
        .BURST_LEN(BURST_LEN), .TAG_DEPTH(TAG_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .tag_count(tag_count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] req_data(input int i);
        return 64'hCAFE_0000_0000_0000 | 64'(i);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_axis_tvalid      = '0;
        bus.m_axis_corr_tready = 1'b0;
        bus.s_axis_corr_tvalid = 1'b0;
        bus.s_axis_corr_tdata  = '0;
        bus.m_axis_tready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_axis_tvalid      = 4'b1111;
        bus.m_axis_corr_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.s_axis_tready !== 4'b0000) $display("FAIL reset_tready: got %b expected 0000", bus.s_axis_tready);
        else n_pass++;
        n_checks++;
        if (bus.m_axis_corr_tvalid !== 1'b0) $display("FAIL reset_corr_tvalid: got %b expected 0", bus.m_axis_corr_tvalid);
        else n_pass++;
        n_checks++;
        if (tag_count !== 4'd0) $display("FAIL reset_tag_count: got %0d expected 0", tag_count);
        else n_pass++;
        n_checks++;
        if (err_underflow !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_underflow);
        else n_pass++;
    endtask

    task automatic test_underflow();
        logic [127:0] rdata;
        rdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        do_reset();
        bus.s_axis_corr_tvalid = 1'b1;
        bus.s_axis_corr_tdata  = rdata;
        bus.m_axis_tready      = 1'b1;
        #1;
        n_checks++;
        if (bus.m_axis_tvalid !== 1'b1) $display("FAIL uf_tvalid: got %b expected 1", bus.m_axis_tvalid);
        else n_pass++;
        n_checks++;
        if (bus.m_axis_tdata !== rdata) $display("FAIL uf_tdata: got %h expected %h", bus.m_axis_tdata, rdata);
        else n_pass++;
        n_checks++;
        if (bus.m_axis_tdest !== 2'd0) $display("FAIL uf_tdest: got %0d expected 0", bus.m_axis_tdest);
        else n_pass++;
        n_checks++;
        if (bus.s_axis_corr_tready !== 1'b1) $display("FAIL uf_corr_tready: got %b expected 1", bus.s_axis_corr_tready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.s_axis_corr_tvalid = 1'b0;
        n_checks++;
        if (err_underflow !== 1'b1) $display("FAIL uf_err_set: got %b expected 1", err_underflow);
        else n_pass++;
        n_checks++;
        if (tag_count !== 4'd0) $display("FAIL uf_tag_count: got %0d expected 0", tag_count);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err_underflow !== 1'b1) $display("FAIL uf_err_sticky: got %b expected 1", err_underflow);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_feed[9];
        int nf, nr, pending, first_cyc;
        exp_feed  = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
        nf        = 0;
        nr        = 0;
        pending   = 0;
        first_cyc = -1;
        do_reset();
        bus.s_axis_tvalid      = 4'b0101;
        bus.m_axis_corr_tready = 1'b1;
        bus.m_axis_tready      = 1'b1;
        for (int cyc = 0; cyc < 100 && nr < 9; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (tag_count !== 4'(pending)) $display("FAIL rr_tag_count cyc %0d: got %0d expected %0d", cyc, tag_count, pending);
            else n_pass++;
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready && nf < 9) begin
                if (first_cyc < 0) first_cyc = cyc;
                n_checks++;
                if (bus.m_axis_corr_tdata !== req_data(exp_feed[nf]))
                    $display("FAIL rr_feed_data beat %0d: got %h expected %h", nf, bus.m_axis_corr_tdata, req_data(exp_feed[nf]));
                else n_pass++;
                n_checks++;
                if (bus.s_axis_tready !== 4'(1 << exp_feed[nf]))
                    $display("FAIL rr_tready beat %0d: got %b expected %b", nf, bus.s_axis_tready, 4'(1 << exp_feed[nf]));
                else n_pass++;
                nf++;
                pending++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                n_checks++;
                if (bus.m_axis_tdest !== 2'(exp_feed[nr]))
                    $display("FAIL rr_tdest result %0d: got %0d expected %0d", nr, bus.m_axis_tdest, exp_feed[nr]);
                else n_pass++;
                n_checks++;
                if (bus.m_axis_tdata !== 128'(nr))
                    $display("FAIL rr_tdata result %0d: got %h expected %h", nr, bus.m_axis_tdata, 128'(nr));
                else n_pass++;
                nr++;
                pending--;
            end
            @(posedge clk);
            #1;
            if (nf >= 9) bus.s_axis_tvalid = 4'b0000;
            bus.s_axis_corr_tvalid = (pending > 0);
            bus.s_axis_corr_tdata  = 128'(nr);
        end
        n_checks++;
        if (first_cyc !== 0) $display("FAIL rr_first_latency: got %0d expected 0", first_cyc);
        else n_pass++;
        n_checks++;
        if (nf !== 9) $display("FAIL rr_feed_count: got %0d expected 9", nf);
        else n_pass++;
        n_checks++;
        if (nr !== 9) $display("FAIL rr_result_count: got %0d expected 9", nr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nf, nf2;
        nf  = 0;
        nf2 = 0;
        do_reset();
        bus.s_axis_tvalid      = 4'b0010;
        bus.m_axis_corr_tready = 1'b1;
        bus.m_axis_tready      = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready) begin
                n_checks++;
                if (bus.m_axis_corr_tdata !== req_data(1))
                    $display("FAIL bp_feed_data beat %0d: got %h expected %h", nf, bus.m_axis_corr_tdata, req_data(1));
                else n_pass++;
                nf++;
            end
        end
        n_checks++;
        if (nf !== 8) $display("FAIL bp_feed_count: got %0d expected 8", nf);
        else n_pass++;
        n_checks++;
        if (tag_count !== 4'd8) $display("FAIL bp_tag_full: got %0d expected 8", tag_count);
        else n_pass++;
        n_checks++;
        if (bus.m_axis_corr_tvalid !== 1'b0) $display("FAIL bp_stall_tvalid: got %b expected 0", bus.m_axis_corr_tvalid);
        else n_pass++;
        n_checks++;
        if (bus.s_axis_tready !== 4'b0000) $display("FAIL bp_stall_tready: got %b expected 0000", bus.s_axis_tready);
        else n_pass++;
        bus.s_axis_corr_tvalid = 1'b1;
        bus.s_axis_corr_tdata  = 128'hBEEF;
        bus.m_axis_tready      = 1'b1;
        #1;
        n_checks++;
        if (bus.m_axis_tdest !== 2'd1) $display("FAIL bp_result_tdest: got %0d expected 1", bus.m_axis_tdest);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.s_axis_corr_tvalid = 1'b0;
        bus.m_axis_tready      = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready) nf2++;
        end
        n_checks++;
        if (nf2 !== 1) $display("FAIL bp_refill_count: got %0d expected 1", nf2);
        else n_pass++;
        n_checks++;
        if (tag_count !== 4'd8) $display("FAIL bp_tag_refull: got %0d expected 8", tag_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int  nf;
        bit  found;
        nf    = 0;
        found = 1'b0;
        do_reset();
        bus.s_axis_tvalid      = 4'b1000;
        bus.m_axis_corr_tready = 1'b1;
        for (int cyc = 0; cyc < 20 && nf < 2; cyc++) begin
            @(negedge clk);
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready) begin
                n_checks++;
                if (bus.m_axis_corr_tdata !== req_data(3))
                    $display("FAIL rm_feed_data beat %0d: got %h expected %h", nf, bus.m_axis_corr_tdata, req_data(3));
                else n_pass++;
                nf++;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (tag_count !== 4'd2) $display("FAIL rm_pre_tag_count: got %0d expected 2", tag_count);
        else n_pass++;
        bus.s_axis_tvalid = 4'b1001;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tag_count !== 4'd0) $display("FAIL rm_tag_count: got %0d expected 0", tag_count);
        else n_pass++;
        n_checks++;
        if (bus.s_axis_tready !== 4'b0000) $display("FAIL rm_tready: got %b expected 0000", bus.s_axis_tready);
        else n_pass++;
        n_checks++;
        if (bus.m_axis_corr_tvalid !== 1'b0) $display("FAIL rm_corr_tvalid: got %b expected 0", bus.m_axis_corr_tvalid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready) begin
                found = 1'b1;
                n_checks++;
                if (bus.m_axis_corr_tdata !== req_data(0))
                    $display("FAIL rm_restart_data: got %h expected %h", bus.m_axis_corr_tdata, req_data(0));
                else n_pass++;
                n_checks++;
                if (bus.s_axis_tready !== 4'b0001) $display("FAIL rm_restart_tready: got %b expected 0001", bus.s_axis_tready);
                else n_pass++;
            end
        end
        n_checks++;
        if (!found) $display("FAIL rm_restart_timeout: got no feed beat expected one within 10 cycles");
        else n_pass++;
    endtask

    task automatic test_grant_hold();
        bit found;
        found = 1'b0;
        do_reset();
        bus.s_axis_tvalid      = 4'b0010;
        bus.m_axis_corr_tready = 1'b1;
        bus.m_axis_tready      = 1'b1;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (bus.m_axis_corr_tvalid && bus.m_axis_corr_tready) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL gh_first_beat: got no feed beat expected one within 10 cycles");
        else n_pass++;
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 4'b0100;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
`ifdef CORR_SCHED_TIMEOUT_EN
            if (c <= 32) begin
                n_checks++;
                if (bus.s_axis_tready !== 4'b0010) $display("FAIL to_hold cyc %0d: got %b expected 0010", c, bus.s_axis_tready);
                else n_pass++;
            end else if (c == 33) begin
                n_checks++;
                if (bus.s_axis_tready !== 4'b0000) $display("FAIL to_idle: got %b expected 0000", bus.s_axis_tready);
                else n_pass++;
            end else begin
                n_checks++;
                if (bus.s_axis_tready !== 4'b0100) $display("FAIL to_regrant: got %b expected 0100", bus.s_axis_tready);
                else n_pass++;
                n_checks++;
                if (bus.m_axis_corr_tdata !== req_data(2))
                    $display("FAIL to_regrant_data: got %h expected %h", bus.m_axis_corr_tdata, req_data(2));
                else n_pass++;
            end
`else
            n_checks++;
            if (bus.s_axis_tready !== 4'b0010) $display("FAIL gh_hold_tready cyc %0d: got %b expected 0010", c, bus.s_axis_tready);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_corr_tvalid !== 1'b0) $display("FAIL gh_hold_tvalid cyc %0d: got %b expected 0", c, bus.m_axis_corr_tvalid);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.s_axis_tvalid      = '0;
        bus.m_axis_corr_tready = 1'b0;
        bus.s_axis_corr_tvalid = 1'b0;
        bus.s_axis_corr_tdata  = '0;
        bus.m_axis_tready      = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) bus.s_axis_tdata[i*SW +: SW] = req_data(i);
        test_reset();
        test_underflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_grant_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
